// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, single-cycle multiply/accumulate/moves,
// and a 32-step restoring divider that stalls the front end while it runs.
module ex_muldiv_unit (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        EX_Start,
    input  logic [3:0]  EX_MulDivOp,
    input  logic [31:0] EX_Read1,
    input  logic [31:0] EX_Read2,
    input  logic        EX_Flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        MulDiv_Stall,
    output logic        MulDiv_Done
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_e;

    state_e      state_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] rem_q, quot_q, dvsr_q, dvd_raw_q;
    logic [4:0]  cnt_q;
    logic        sgn_dvd_q, sgn_dvs_q, signed_q, dz_q, done_q;

    logic        is_div, op_signed;
    logic [31:0] dvd_abs, dvs_abs;
    logic [63:0] prod_s, prod_u, acc;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_d, quot_d, q_fix, r_fix;

    assign is_div    = (EX_MulDivOp == OP_DIV) || (EX_MulDivOp == OP_DIVU);
    assign op_signed = (EX_MulDivOp == OP_DIV);
    assign dvd_abs   = (op_signed && EX_Read1[31]) ? -EX_Read1 : EX_Read1;
    assign dvs_abs   = (op_signed && EX_Read2[31]) ? -EX_Read2 : EX_Read2;

    // Zero/sign extension to 64 bits makes the truncated product exact in both flavours.
    assign prod_s = {{32{EX_Read1[31]}}, EX_Read1} * {{32{EX_Read2[31]}}, EX_Read2};
    assign prod_u = {32'd0, EX_Read1} * {32'd0, EX_Read2};
    assign acc    = {hi_q, lo_q};

    // A set top bit after the shift means the partial remainder already exceeds any divisor.
    assign rem_sh = {rem_q, quot_q[31]};
    assign ge     = rem_sh[32] || (rem_sh[31:0] >= dvsr_q);
    assign rem_d  = ge ? (rem_sh[31:0] - dvsr_q) : rem_sh[31:0];
    assign quot_d = {quot_q[30:0], ge};

    assign q_fix = (signed_q && (sgn_dvd_q ^ sgn_dvs_q)) ? -quot_q : quot_q;
    assign r_fix = (signed_q && sgn_dvd_q) ? -rem_q : rem_q;

    assign MulDiv_Stall = (state_q != S_IDLE) ||
                          (EX_Start && is_div && !EX_Flush);
    assign MulDiv_Done  = done_q;
    assign HI           = hi_q;
    assign LO           = lo_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            dvd_raw_q <= '0;
            cnt_q     <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            signed_q  <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (EX_Start && !EX_Flush) begin
                        case (EX_MulDivOp)
                            OP_MULT:  {hi_q, lo_q} <= prod_s;
                            OP_MULTU: {hi_q, lo_q} <= prod_u;
                            OP_MADD:  {hi_q, lo_q} <= acc + prod_s;
                            OP_MSUB:  {hi_q, lo_q} <= acc - prod_s;
                            OP_MTHI:  hi_q <= EX_Read1;
                            OP_MTLO:  lo_q <= EX_Read1;
                            OP_DIV, OP_DIVU: begin
                                signed_q  <= op_signed;
                                sgn_dvd_q <= EX_Read1[31];
                                sgn_dvs_q <= EX_Read2[31];
                                dvd_raw_q <= EX_Read1;
                                dz_q      <= (EX_Read2 == 32'd0);
                                quot_q    <= dvd_abs;
                                dvsr_q    <= dvs_abs;
                                rem_q     <= '0;
                                cnt_q     <= '0;
                                state_q   <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV: begin
                    if (EX_Flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!EX_Flush) begin
                        hi_q   <= dz_q ? dvd_raw_q : r_fix;
                        lo_q   <= dz_q ? 32'hFFFF_FFFF : q_fix;
                        done_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table for single-cycle ops and divides,
// plus hand sequences for reset/flush/back-to-back corners.
module tb_ex_muldiv_unit;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        EX_Start = 1'b0;
    logic        EX_Flush = 1'b0;
    logic [3:0]  EX_MulDivOp = 4'd0;
    logic [31:0] EX_Read1 = 32'd0;
    logic [31:0] EX_Read2 = 32'd0;
    logic [31:0] HI, LO;
    logic        MulDiv_Stall, MulDiv_Done;

    ex_muldiv_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .EX_Start(EX_Start), .EX_MulDivOp(EX_MulDivOp),
        .EX_Read1(EX_Read1), .EX_Read2(EX_Read2), .EX_Flush(EX_Flush),
        .HI(HI), .LO(LO), .MulDiv_Stall(MulDiv_Stall), .MulDiv_Done(MulDiv_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } vec_t;

    localparam int NV = 16;
    vec_t tv [NV];

    int pass_cnt = 0;
    int total = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        EX_Start = 1'b1; EX_MulDivOp = op; EX_Read1 = a; EX_Read2 = b; EX_Flush = fl;
    endtask

    task automatic idle_inputs();
        EX_Start = 1'b0; EX_MulDivOp = 4'd0; EX_Flush = 1'b0;
    endtask

    // Single-cycle op issued at a negedge; returns at the next negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        drive(op, a, b, fl);
        #1 chk("no_stall_single", {31'd0, MulDiv_Stall}, 32'd0);
        @(negedge Clk);
        idle_inputs();
    endtask

    // Returns in the first cycle after the commit edge, with Done expected high.
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int cyc;
        int early_dn;
        logic hold_ok;
        drive(op, a, b, 1'b0);
        #1 chk({nm, " stall_issue"}, {31'd0, MulDiv_Stall}, 32'd1);
        @(negedge Clk);
        idle_inputs();
        cyc = 1; early_dn = 0; hold_ok = 1'b1;
        for (int i = 0; i < 40 && MulDiv_Stall; i++) begin
            if (HI !== cur_hi || LO !== cur_lo) hold_ok = 1'b0;
            if (MulDiv_Done) early_dn++;
            cyc++;
            @(negedge Clk);
        end
        chk({nm, " stall_cycles"}, 32'(cyc), 32'd34);
        chk({nm, " hilo_hold"}, {31'd0, hold_ok}, 32'd1);
        chk({nm, " early_done"}, 32'(early_dn), 32'd0);
        chk({nm, " done"}, {31'd0, MulDiv_Done}, 32'd1);
        chk({nm, " HI"}, HI, ehi);
        chk({nm, " LO"}, LO, elo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        tv[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult"};
        tv[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu"};
        tv[2]  = '{OP_MADD,  32'd3,        32'd4,        32'h00000002, 32'h0000000A, "madd"};
        tv[3]  = '{OP_MSUB,  32'd3,        32'd4,        32'h00000001, 32'hFFFFFFFE, "msub"};
        tv[4]  = '{OP_MSUB,  32'hFFFFFFFF, 32'd1,        32'h00000001, 32'hFFFFFFFF, "msub_neg"};
        tv[5]  = '{OP_MTHI,  32'hDEADBEEF, 32'd7,        32'hDEADBEEF, 32'hFFFFFFFF, "mthi"};
        tv[6]  = '{OP_MTLO,  32'h12345678, 32'd7,        32'hDEADBEEF, 32'h12345678, "mtlo"};
        tv[7]  = '{4'h0,     32'd5,        32'd6,        32'hDEADBEEF, 32'h12345678, "nop0"};
        tv[8]  = '{4'hF,     32'd5,        32'd6,        32'hDEADBEEF, 32'h12345678, "nopF"};
        tv[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
        tv[10] = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "divu_by0"};
        tv[11] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        tv[12] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_by0"};
        tv[13] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
        tv[14] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_big"};
        tv[15] = '{OP_MADD,  32'hFFFFFFFE, 32'd3,        32'h0000000F, 32'h0FFFFFF9, "madd_neg"};

        #1;
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset stall", {31'd0, MulDiv_Stall}, 32'd0);
        chk("reset done", {31'd0, MulDiv_Done}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < NV; i++) begin
            if (tv[i].op == OP_DIV || tv[i].op == OP_DIVU) begin
                run_div(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].nm);
            end else begin
                issue(tv[i].op, tv[i].a, tv[i].b, 1'b0);
                chk({tv[i].nm, " HI"}, HI, tv[i].hi);
                chk({tv[i].nm, " LO"}, LO, tv[i].lo);
            end
            cur_hi = tv[i].hi;
            cur_lo = tv[i].lo;
        end

        // Reset in the 10th cycle of a divide
        drive(OP_DIVU, 32'd9, 32'd4, 1'b0);
        @(negedge Clk);
        idle_inputs();
        repeat (9) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("rstmid HI", HI, 32'd0);
        chk("rstmid LO", LO, 32'd0);
        chk("rstmid stall", {31'd0, MulDiv_Stall}, 32'd0);
        chk("rstmid done", {31'd0, MulDiv_Done}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            dn += int'(MulDiv_Done);
        end
        chk("rstmid no_done", 32'(dn), 32'd0);
        chk("rstmid stall_after", {31'd0, MulDiv_Stall}, 32'd0);

        // Flush at step 15 of a divide
        issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h12345678, 32'd0, 1'b0);
        drive(OP_DIV, 32'd1000, 32'd3, 1'b0);
        @(negedge Clk);
        idle_inputs();
        repeat (14) @(negedge Clk);
        EX_Flush = 1'b1;
        @(negedge Clk);
        EX_Flush = 1'b0;
        #1;
        chk("flush stall", {31'd0, MulDiv_Stall}, 32'd0);
        chk("flush HI", HI, 32'h12345678);
        chk("flush LO", LO, 32'h12345678);
        dn = 0;
        repeat (40) begin
            @(negedge Clk);
            dn += int'(MulDiv_Done);
        end
        chk("flush no_done", 32'(dn), 32'd0);
        chk("flush HI_late", HI, 32'h12345678);
        chk("flush LO_late", LO, 32'h12345678);

        // Flush wins over a simultaneous start
        issue(OP_MTHI, 32'hCAFEF00D, 32'd0, 1'b1);
        chk("flush_mthi HI", HI, 32'h12345678);
        drive(OP_DIVU, 32'd50, 32'd5, 1'b1);
        #1 chk("flush_div stall_issue", {31'd0, MulDiv_Stall}, 32'd0);
        @(negedge Clk);
        idle_inputs();
        chk("flush_div stall_next", {31'd0, MulDiv_Stall}, 32'd0);
        chk("flush_div LO", LO, 32'h12345678);
        cur_hi = 32'h12345678;
        cur_lo = 32'h12345678;

        // Back-to-back: MTLO issued in the cycle right after the commit
        run_div(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, "b2b_divu");
        issue(OP_MTLO, 32'hA5A5A5A5, 32'd0, 1'b0);
        chk("b2b LO", LO, 32'hA5A5A5A5);
        chk("b2b HI", HI, 32'd1);
        chk("b2b done_low", {31'd0, MulDiv_Done}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
